// File: rtl/bit_serial_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : bit_serial_adder                                            |
// | Desc     : WIDTH-cycle LSB-first serial adder with one gate-level FA.  |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module bit_serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             busy,
  output logic             done
);

  localparam int              c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_add  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_sr;
  logic               r_c;
  logic [c_cnt_w-1:0] r_cnt;

  logic w_p;
  logic w_g;
  logic w_t;
  logic w_sum;
  logic w_cout;

  // Single full-adder slice from 2-input gates only
  xor u_xor_p   (w_p,    r_sa[0], r_sb[0]);
  xor u_xor_s   (w_sum,  w_p,     r_c);
  and u_and_g   (w_g,    r_sa[0], r_sb[0]);
  and u_and_t   (w_t,    r_c,     w_p);
  or  u_or_cout (w_cout, w_g,     w_t);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = c_st_idle;
    case (r_state)
      c_st_idle: w_state_nxt = start ? c_st_add : c_st_idle;
      c_st_add:  w_state_nxt = (r_cnt == c_last) ? c_st_done : c_st_add;
      c_st_done: w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    busy = (r_state == c_st_add);
    done = (r_state == c_st_done);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_sr  <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
      s     <= '0;
      co    <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_c   <= ci;
            r_cnt <= '0;
          end
        end
        c_st_add: begin
          r_sr  <= {w_sum, r_sr[WIDTH-1:1]};
          r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
          r_c   <= w_cout;
          r_cnt <= r_cnt + 1'b1;
          // Final bit: publish the fully assembled sum in the same edge
          if (r_cnt == c_last) begin
            s  <= {w_sum, r_sr[WIDTH-1:1]};
            co <= w_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_bit_serial_adder                                         |
// | Desc     : Randomized self-checking bench, WIDTH=4 and WIDTH=8 DUTs.   |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_bit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       start4, ci4, co4, busy4, done4;
  logic [3:0] a4, b4, s4;
  logic       start8, ci8, co8, busy8, done8;
  logic [7:0] a8, b8, s8;

  bit_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4), .ci(ci4),
    .s(s4), .co(co4), .busy(busy4), .done(done4)
  );

  bit_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .ci(ci8),
    .s(s8), .co(co8), .busy(busy8), .done(done8)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  int         cur_w   = 4;
  logic [8:0] prev_res4;
  logic [8:0] prev_res8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (w=%0d t=%0t): got=%0h exp=%0h", tag, cur_w, $time, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] av, input logic [7:0] bv, input logic cv);
    if (cur_w == 8) begin
      start8 = st; a8 = av; b8 = bv; ci8 = cv;
    end else begin
      start4 = st; a4 = av[3:0]; b4 = bv[3:0]; ci4 = cv;
    end
  endtask

  function automatic logic [8:0] obs_res();
    return (cur_w == 8) ? {co8, s8} : {4'b0, co4, s4};
  endfunction

  function automatic logic obs_busy();
    return (cur_w == 8) ? busy8 : busy4;
  endfunction

  function automatic logic obs_done();
    return (cur_w == 8) ? done8 : done4;
  endfunction

  // mode 0: start low while running; 1: random start/operands while running;
  // 2: start held high throughout and left high for back-to-back issue.
  // Must be called at a negedge; returns at the negedge before E0+WIDTH+2.
  task automatic do_op(input logic [7:0] av_in, input logic [7:0] bv_in, input logic cv, input int mode);
    logic [7:0] av, bv;
    logic [8:0] exp, prev;
    av   = av_in & 8'((1 << cur_w) - 1);
    bv   = bv_in & 8'((1 << cur_w) - 1);
    exp  = 9'(av) + 9'(bv) + 9'(cv);
    prev = (cur_w == 8) ? prev_res8 : prev_res4;
    drive(1'b1, av, bv, cv);
    @(posedge clk);
    for (int k = 1; k <= cur_w; k++) begin
      @(negedge clk);
      check("busy_in_add", obs_busy(), 1);
      check("no_early_done", obs_done(), 0);
      check("prev_result_held", obs_res(), prev);
      case (mode)
        0:       drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        1:       drive(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        default: drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      endcase
      @(posedge clk);
    end
    @(negedge clk);
    check("done_pulse", obs_done(), 1);
    check("busy_off_in_done", obs_busy(), 0);
    check("result", obs_res(), exp);
    drive((mode == 0) ? 1'b0 : 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", obs_done(), 0);
    check("idle_not_busy", obs_busy(), 0);
    check("result_hold", obs_res(), exp);
    if (mode != 2) drive(1'b0, 8'h00, 8'h00, 1'b0);
    if (cur_w == 8) prev_res8 = exp;
    else            prev_res4 = exp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    prev_res4 = '0;
    prev_res8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res4", {co4, s4}, 0);
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_res8", {co8, s8}, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    reset_n = 1'b1;

    cur_w = 4;
    do_op(8'h3, 8'h5, 1'b0, 0);
    do_op(8'hF, 8'h1, 1'b0, 0);
    do_op(8'hF, 8'hF, 1'b1, 0);

    // Abort mid-ADD with an asynchronous reset pulse placed off the clock edge
    drive(1'b1, 8'h9, 8'h6, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'h0, 8'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("abort_res", obs_res(), 0);
    check("abort_busy", obs_busy(), 0);
    check("abort_done", obs_done(), 0);
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_held", obs_busy(), 0);
    reset_n = 1'b1;
    prev_res4 = '0;
    prev_res8 = '0;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_done", obs_done(), 0);
    end
    do_op(8'h1, 8'h1, 1'b0, 0);

    // Second start during ADD must be ignored
    do_op(8'h2, 8'h2, 1'b0, 1);
    repeat (2) @(negedge clk);

    // start held high: periodic issue every WIDTH+2 edges
    repeat (4) do_op(8'($urandom), 8'($urandom), 1'($urandom), 2);
    drive(1'b0, 8'h0, 8'h0, 1'b0);
    @(negedge clk);

    repeat (20) do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
    do_op(8'hF, 8'hF, 1'b1, 0);
    do_op(8'h0, 8'h0, 1'b0, 0);

    cur_w = 8;
    do_op(8'hAA, 8'h55, 1'b1, 0);
    do_op(8'h00, 8'h00, 1'b0, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 1);
    repeat (20) do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    drive(1'b0, 8'h0, 8'h0, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
